// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with Moore-decoded control outputs.
module main_fsm #(
  parameter int STATE_W      = 4,
  parameter int MEM_WAIT     = 0,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_INIT     = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       illegal;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.irwrite = 1'b1; c.pcupdate = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
      S_DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      S_MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      S_MEMREAD:  c.adrsrc = 1'b1;
      S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
      S_EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      S_ALUWB:    c.regwrite = 1'b1;
      S_BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
      S_ERROR:    c.illegal = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_ready;
  logic   w_fetch_ok;

  assign w_ready = (MEM_WAIT == 0) || MemReady;

  always_comb begin
    w_next = S_INIT;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = (ILLEGAL_TRAP != 0) ? S_ERROR : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB, S_ALUWB, S_BEQ: w_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
      S_INIT:     w_next = S_FETCH;
      S_ERROR:    w_next = S_ERROR;
      default:    w_next = S_INIT;
    endcase
  end

  // Control word is registered from the next state so it lines up with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode(w_next);
    end
  end

  // irwrite is only set in FETCH; a stalled fetch suppresses both strobes.
  assign w_fetch_ok = !r_ctrl.irwrite || w_ready;

  assign PCWrite   = (r_ctrl.pcupdate && w_fetch_ok) || (r_ctrl.branch && Zero);
  assign IRWrite   = r_ctrl.irwrite && w_ready;
  assign AdrSrc    = r_ctrl.adrsrc;
  assign MemWrite  = r_ctrl.memwrite;
  assign RegWrite  = r_ctrl.regwrite;
  assign ResultSrc = r_ctrl.resultsrc;
  assign ALUSrcA   = r_ctrl.alusrca;
  assign ALUSrcB   = r_ctrl.alusrcb;
  assign ALUOp     = r_ctrl.aluop;
  assign IllegalOp = r_ctrl.illegal;
  assign state_dbg = r_state;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: two instances (waiting/trapping and non-waiting/non-trapping)
// checked every cycle against an instruction-sequence reference model.
module tb_main_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = OP_R;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;

  logic       a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill;
  logic [1:0] a_res, a_asa, a_asb, a_aop, a_imm;
  logic [3:0] a_state;
  logic       b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
  logic [1:0] b_res, b_asa, b_asb, b_aop, b_imm;
  logic [3:0] b_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  main_fsm #(.STATE_W(4), .MEM_WAIT(1), .ILLEGAL_TRAP(1)) u_a (
    .clk(clk), .reset_n(reset_n), .op(op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw), .IRWrite(a_irw), .RegWrite(a_rw),
    .ResultSrc(a_res), .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ALUOp(a_aop), .ImmSrc(a_imm),
    .IllegalOp(a_ill), .state_dbg(a_state)
  );

  main_fsm #(.STATE_W(4), .MEM_WAIT(0), .ILLEGAL_TRAP(0)) u_b (
    .clk(clk), .reset_n(reset_n), .op(op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw), .IRWrite(b_irw), .RegWrite(b_rw),
    .ResultSrc(b_res), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ALUOp(b_aop), .ImmSrc(b_imm),
    .IllegalOp(b_ill), .state_dbg(b_state)
  );

  logic [18:0] act [2];
  assign act[0] = {a_state, a_pcw, a_adr, a_mw, a_irw, a_rw, a_res, a_asa, a_asb, a_aop, a_imm, a_ill};
  assign act[1] = {b_state, b_pcw, b_adr, b_mw, b_irw, b_rw, b_res, b_asa, b_asb, b_aop, b_imm, b_ill};

  // Reference model: current phase plus the list of phases left in this instruction.
  int m_cur [2] = '{11, 11};
  int m_prog [2][3];
  int m_idx [2];
  int m_len [2];

  function automatic bit waits(input int d);
    return d == 0;
  endfunction

  function automatic bit traps(input int d);
    return d == 0;
  endfunction

  function automatic logic [14:0] spec_outs(input int s);
    logic pcu, br, adr, mw, irw, rw, ill;
    logic [1:0] res, a, b, aop;
    {pcu, br, adr, mw, irw, rw, ill} = '0;
    {res, a, b, aop} = '0;
    case (s)
      0:  begin pcu = 1; irw = 1; res = 2'b10; b = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1;
      4:  begin res = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2'b10; aop = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      8:  rw = 1;
      9:  begin a = 2'b10; aop = 2'b01; br = 1; end
      10: begin a = 2'b01; b = 2'b10; pcu = 1; end
      12: ill = 1;
      default: ;
    endcase
    return {pcu, br, adr, mw, irw, rw, res, a, b, aop, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OP_SW) return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [18:0] exp_vec(input int d);
    logic [14:0] o;
    logic stall, pcw, irw;
    o     = spec_outs(m_cur[d]);
    stall = (m_cur[d] == 0) && waits(d) && !MemReady;
    pcw   = (o[14] && !stall) || (o[13] && Zero);
    irw   = o[10] && !stall;
    return {4'(m_cur[d]), pcw, o[12], o[11], irw, o[9], o[8:7], o[6:5], o[4:3], o[2:1], imm_of(op), o[0]};
  endfunction

  task automatic load_prog(input int d);
    m_idx[d] = 0;
    m_len[d] = 0;
    case (op)
      OP_LW:  begin m_prog[d][0] = 2;  m_prog[d][1] = 3; m_prog[d][2] = 4; m_len[d] = 3; end
      OP_SW:  begin m_prog[d][0] = 2;  m_prog[d][1] = 5; m_len[d] = 2; end
      OP_R:   begin m_prog[d][0] = 6;  m_prog[d][1] = 8; m_len[d] = 2; end
      OP_I:   begin m_prog[d][0] = 7;  m_prog[d][1] = 8; m_len[d] = 2; end
      OP_BEQ: begin m_prog[d][0] = 9;  m_len[d] = 1; end
      OP_JAL: begin m_prog[d][0] = 10; m_prog[d][1] = 8; m_len[d] = 2; end
      default: if (traps(d)) begin m_prog[d][0] = 12; m_len[d] = 1; end
    endcase
  endtask

  task automatic model_step(input int d);
    bit rdy;
    rdy = !waits(d) || MemReady;
    if (!reset_n) begin
      m_cur[d] = 11; m_len[d] = 0;
    end else if (m_cur[d] == 11) begin
      m_cur[d] = 0;
    end else if (m_cur[d] == 12) begin
      m_cur[d] = 12;
    end else if ((m_cur[d] == 0 || m_cur[d] == 3 || m_cur[d] == 5) && !rdy) begin
      m_cur[d] = m_cur[d];
    end else if (m_cur[d] == 0) begin
      load_prog(d);
      m_cur[d] = 1;
    end else if (m_idx[d] < m_len[d]) begin
      m_cur[d] = m_prog[d][m_idx[d]];
      m_idx[d]++;
    end else begin
      m_cur[d] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
  endtask

  task automatic force_reset_model();
    for (int d = 0; d < 2; d++) begin m_cur[d] = 11; m_len[d] = 0; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    force_reset_model();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    MemReady = 1'b1; op = OP_R; Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL reset_hold dut%0d t=%0t got=%h exp=%h", d, $time, act[d], exp_vec(d));
        end
      end
      tick();
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a_state, a_irw, a_pcw, a_rw, a_mw} !== {4'd11, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_init got=%h exp=%h", {a_state, a_irw, a_pcw, a_rw, a_mw}, {4'd11, 4'b0000});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({a_state, a_irw, a_pcw} !== {4'd0, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_fetch got=%h exp=%h", {a_state, a_irw, a_pcw}, {4'd0, 2'b11});
    end
    tick();
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [3];
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_JAL;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      op = ops[k];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if (act[d] !== exp_vec(d)) begin
            miscompares++;
            $display("FAIL alu_seq op=%b dut%0d cyc=%0d got=%h exp=%h", op, d, c, act[d], exp_vec(d));
          end
        end
        tick();
      end
      @(negedge clk);
      vectors++;
      if (a_state !== 4'd0) begin
        miscompares++;
        $display("FAIL alu_cpi4 op=%b state got=%0d exp=0", op, a_state);
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    int waited, cycles, memread_cycles;
    waited = 0; cycles = 0; memread_cycles = 0;
    do_reset();
    op = OP_LW;
    while (!(cycles > 0 && m_cur[0] == 0) && cycles < 12) begin
      MemReady = !(m_cur[0] == 3 && waited < 2);
      if (!MemReady) waited++;
      @(negedge clk);
      if (a_state == 4'd3) memread_cycles++;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL lw_wait dut%0d cyc=%0d got=%h exp=%h", d, cycles, act[d], exp_vec(d));
        end
      end
      tick();
      cycles++;
    end
    MemReady = 1'b1;
    vectors++;
    if (cycles !== 7 || memread_cycles !== 3) begin
      miscompares++;
      $display("FAIL lw_cpi cycles got=%0d exp=7 memread got=%0d exp=3", cycles, memread_cycles);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      op = OP_BEQ;
      Zero = z[0];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if (act[d] !== exp_vec(d)) begin
            miscompares++;
            $display("FAIL beq_seq zero=%0d dut%0d cyc=%0d got=%h exp=%h", z, d, c, act[d], exp_vec(d));
          end
        end
        if (c == 2) begin
          vectors++;
          if ({a_state, a_pcw} !== {4'd9, z[0]}) begin
            miscompares++;
            $display("FAIL beq_pcwrite zero=%0d got=%h exp=%h", z, {a_state, a_pcw}, {4'd9, z[0]});
          end
        end
        tick();
      end
      vectors++;
      if (m_cur[0] != 1 || a_state !== 4'd1) begin
        miscompares++;
        $display("FAIL beq_next got=%0d exp=1", a_state);
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    op = 7'b1111111;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL illegal_seq dut%0d cyc=%0d got=%h exp=%h", d, c, act[d], exp_vec(d));
        end
      end
      if (c >= 2) begin
        vectors++;
        if ({a_state, a_ill} !== {4'd12, 1'b1}) begin
          miscompares++;
          $display("FAIL illegal_sticky cyc=%0d got=%h exp=%h", c, {a_state, a_ill}, {4'd12, 1'b1});
        end
      end
      tick();
    end
    reset_n = 1'b0;
    force_reset_model();
    #1;
    vectors++;
    if ({a_state, a_ill} !== {4'd11, 1'b0}) begin
      miscompares++;
      $display("FAIL illegal_reset got=%h exp=%h", {a_state, a_ill}, {4'd11, 1'b0});
    end
    op = OP_R;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_memwrite();
    int c;
    bit hit;
    c = 0; hit = 0;
    do_reset();
    op = OP_SW;
    while (!hit && c < 10) begin
      MemReady = (m_cur[0] != 5);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL sw_seq dut%0d cyc=%0d got=%h exp=%h", d, c, act[d], exp_vec(d));
        end
      end
      if (m_cur[0] == 5) hit = 1;
      else tick();
      c++;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL sw_reach_memwrite got=0 exp=1");
    end
    #2;
    reset_n = 1'b0;
    force_reset_model();
    #1;
    vectors++;
    if ({a_state, a_mw, a_rw, a_adr} !== {4'd11, 3'b000}) begin
      miscompares++;
      $display("FAIL memwrite_reset got=%h exp=%h", {a_state, a_mw, a_rw, a_adr}, {4'd11, 3'b000});
    end
    #1;
    reset_n = 1'b1;
    MemReady = 1'b1;
    tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (act[d] !== exp_vec(d)) begin
        miscompares++;
        $display("FAIL memwrite_recover dut%0d got=%h exp=%h", d, act[d], exp_vec(d));
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] legal [6];
    legal[0] = OP_LW; legal[1] = OP_SW; legal[2] = OP_R;
    legal[3] = OP_I;  legal[4] = OP_BEQ; legal[5] = OP_JAL;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!(m_cur[0] inside {1, 2}) && !(m_cur[1] inside {1, 2}) && $urandom_range(0, 1) == 1)
        op = legal[$urandom_range(0, 5)];
      Zero = 1'($urandom);
      MemReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL random dut%0d cyc=%0d op=%b got=%h exp=%h", d, c, op, act[d], exp_vec(d));
        end
      end
      tick();
    end
    MemReady = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_reset_memwrite();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
